// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Types and constants shared by the instruction-memory loader and the
//   instruction RAM it feeds.
//   - IMEM_SIZE_DEFAULT : default instruction memory size in bytes
//   - loader_state_t    : loader FSM states
package imem_loader_pkg;

    localparam int IMEM_SIZE_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte stream carrying the program image into the loader.
//   - in_valid / in_ready : handshake, byte moves when both are high
//   - in_data             : byte payload
//   - in_last             : final byte of the image
//   master = byte source (host/UART side), slave = loader.
interface imem_loader_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Collects accepted bytes into 32-bit words.
//   - clk, reset : clock, synchronous active-high reset
//   - clear      : restart at byte index 0 (new load)
//   - byte_en    : a byte is being accepted this cycle
//   - byte_in    : the byte
//   - word_valid : combinational, high when byte_en completes a word
//   - word       : packed word including byte_in (meaningful with word_valid)
//   MSB_FIRST=1 places the first byte at [31:24], otherwise at [7:0].
module byte_packer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] sh_q, sh_d;

    always_comb begin
        idx_d      = idx_q;
        sh_d       = sh_q;
        // The shift register already holds the earlier bytes in their final
        // lanes once the new byte is appended, so word is valid on byte 4.
        word       = MSB_FIRST ? {sh_q[23:0], byte_in} : {byte_in, sh_q[31:8]};
        word_valid = byte_en && (idx_q == 2'd3);
        if (clear) begin
            idx_d = 2'd0;
            sh_d  = 32'd0;
        end else if (byte_en) begin
            idx_d = idx_q + 2'd1;
            sh_d  = word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
            sh_q  <= 32'd0;
        end else begin
            idx_q <= idx_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction memory writer. Packs a byte stream into words,
//   writes them from address 0 upward, and holds the CPU until a full image
//   has been loaded.
//   - clk, reset   : clock, synchronous active-high reset
//   - start        : pulse, begin a new load (ignored while loading)
//   - in_s         : byte stream (valid/ready/data/last)
//   - wr_en/wr_address/wr_data : instruction RAM write port
//   - cpu_hold     : low only after a successful load
//   - done / error : load result levels
//   - words_loaded / checksum  : words written and their mod-2^32 sum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int  INSTRUCT_MEM_SIZE = IMEM_SIZE_DEFAULT,
    parameter bit  MSB_FIRST         = 1'b1,
    localparam int WL_W              = $clog2(INSTRUCT_MEM_SIZE / 4) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      in_s,
    output logic              wr_en,
    output logic [31:0]       wr_address,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [WL_W-1:0]   words_loaded,
    output logic [31:0]       checksum
);

    localparam int WORDS = INSTRUCT_MEM_SIZE / 4;

    loader_state_t    state_q, state_d;
    logic             fin_q, fin_d;        // final word written, DONE next edge
    logic             in_ready_q, in_ready_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_address_q, wr_address_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [31:0]      addr_q, addr_d;
    logic [WL_W-1:0]  wl_q, wl_d;
    logic [31:0]      cks_q, cks_d;

    logic             accept;
    logic             pk_clear, pk_en;
    logic             word_valid;
    logic [31:0]      word;

    byte_packer #(.MSB_FIRST(MSB_FIRST)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .byte_en   (pk_en),
        .byte_in   (in_s.in_data),
        .word_valid(word_valid),
        .word      (word)
    );

    assign accept = in_s.in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        fin_d        = fin_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        addr_d       = addr_q;
        wl_d         = wl_q;
        cks_d        = cks_q;
        pk_clear     = 1'b0;
        pk_en        = 1'b0;
        case (state_q)
            LOAD: begin
                if (fin_q) begin
                    // Written final word is visible for one cycle before done.
                    state_d = DONE;
                    fin_d   = 1'b0;
                end else if (accept) begin
                    if (wl_q == WL_W'(WORDS)) begin
                        state_d = ERROR;        // image larger than memory
                    end else begin
                        pk_en = 1'b1;
                        if (word_valid) begin
                            wr_en_d      = 1'b1;
                            wr_address_d = addr_q;
                            wr_data_d    = word;
                            addr_d       = addr_q + 32'd4;
                            wl_d         = wl_q + 1'b1;
                            cks_d        = cks_q + word;
                            fin_d        = in_s.in_last;
                        end else if (in_s.in_last) begin
                            state_d = ERROR;    // image ends mid-word
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d  = LOAD;
                    fin_d    = 1'b0;
                    addr_d   = 32'd0;
                    wl_d     = '0;
                    cks_d    = 32'd0;
                    pk_clear = 1'b1;
                end
            end
        endcase
        // Registered from next state so ready never depends on in_valid.
        in_ready_d = (state_d == LOAD) && !fin_d;
        cpu_hold_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fin_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_address_q <= 32'd0;
            wr_data_q    <= 32'd0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= 32'd0;
            wl_q         <= '0;
            cks_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            fin_q        <= fin_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            wl_q         <= wl_d;
            cks_q        <= cks_d;
        end
    end

    assign in_s.in_ready = in_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_address    = wr_address_q;
    assign wr_data       = wr_data_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = wl_q;
    assign checksum      = cks_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench: one MSB-first and one LSB-first loader fed the same
//   byte stream; writes captured into queues and compared to hand values.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset, start, v, l;
    logic [7:0] d;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    imem_loader_if bus_m();
    imem_loader_if bus_l();
    assign bus_m.in_valid = v;
    assign bus_m.in_data  = d;
    assign bus_m.in_last  = l;
    assign bus_l.in_valid = v;
    assign bus_l.in_data  = d;
    assign bus_l.in_last  = l;

    logic        wr_en_m, hold_m, done_m, err_m;
    logic [31:0] addr_m, data_m, cks_m;
    logic [8:0]  wl_m;
    logic        wr_en_l, hold_l, done_l, err_l;
    logic [31:0] addr_l, data_l, cks_l;
    logic [8:0]  wl_l;

    imem_loader #(.INSTRUCT_MEM_SIZE(1024), .MSB_FIRST(1'b1)) u_dut_m (
        .clk(clk), .reset(reset), .start(start), .in_s(bus_m),
        .wr_en(wr_en_m), .wr_address(addr_m), .wr_data(data_m),
        .cpu_hold(hold_m), .done(done_m), .error(err_m),
        .words_loaded(wl_m), .checksum(cks_m)
    );

    imem_loader #(.INSTRUCT_MEM_SIZE(1024), .MSB_FIRST(1'b0)) u_dut_l (
        .clk(clk), .reset(reset), .start(start), .in_s(bus_l),
        .wr_en(wr_en_l), .wr_address(addr_l), .wr_data(data_l),
        .cpu_hold(hold_l), .done(done_l), .error(err_l),
        .words_loaded(wl_l), .checksum(cks_l)
    );

    logic [31:0] qa_m[$], qd_m[$], qd_l[$];

    always @(negedge clk) begin
        if (wr_en_m) begin
            qa_m.push_back(addr_m);
            qd_m.push_back(data_m);
        end
        if (wr_en_l) qd_l.push_back(data_l);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Called and returns on a negedge; the byte is taken on the posedge between.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        v = 1'b1; d = b; l = last;
        while (!bus_m.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_m.in_ready) chk("ready_timeout", {31'd0, bus_m.in_ready}, 32'd1);
        @(negedge clk);
        v = 1'b0; l = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[7:0],   last);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {31'd0, bus_m.in_ready}, 32'd0);
        chk({tag, "_wren"},  {31'd0, wr_en_m}, 32'd0);
        chk({tag, "_addr"},  addr_m, 32'd0);
        chk({tag, "_data"},  data_m, 32'd0);
        chk({tag, "_hold"},  {31'd0, hold_m}, 32'd1);
        chk({tag, "_done"},  {31'd0, done_m}, 32'd0);
        chk({tag, "_err"},   {31'd0, err_m}, 32'd0);
        chk({tag, "_wl"},    {23'd0, wl_m}, 32'd0);
        chk({tag, "_cks"},   cks_m, 32'd0);
    endtask

    task automatic clear_q();
        qa_m.delete();
        qd_m.delete();
        qd_l.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; v = 1'b0; l = 1'b0; d = 8'h00;
        idle(3);
        chk_reset_state("rst");
        reset = 1'b0;
        idle(1);

        // single word DEADBEEF
        pulse_start();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b1);
        chk("t1_wren", {31'd0, wr_en_m}, 32'd1);
        chk("t1_done_early", {31'd0, done_m}, 32'd0);
        idle(1);
        chk("t1_done", {31'd0, done_m}, 32'd1);
        chk("t1_hold", {31'd0, hold_m}, 32'd0);
        chk("t1_err",  {31'd0, err_m}, 32'd0);
        chk("t1_wl",   {23'd0, wl_m}, 32'd1);
        chk("t1_cks",  cks_m, 32'hDEADBEEF);
        idle(2);
        chk("t1_nwr",  qa_m.size(), 32'd1);
        if (qa_m.size() > 0) begin
            chk("t1_addr", qa_m[0], 32'd0);
            chk("t1_data", qd_m[0], 32'hDEADBEEF);
        end
        clear_q();

        // restart from DONE; three words with gaps; start mid-load ignored
        pulse_start();
        chk("t2_wl_clr",  {23'd0, wl_m}, 32'd0);
        chk("t2_cks_clr", cks_m, 32'd0);
        chk("t2_done_clr", {31'd0, done_m}, 32'd0);
        chk("t2_hold", {31'd0, hold_m}, 32'd1);
        send_word(32'd1, 1'b0);
        idle(2);
        pulse_start();
        send_word(32'd2, 1'b0);
        idle(3);
        send_word(32'd3, 1'b1);
        idle(2);
        chk("t2_done", {31'd0, done_m}, 32'd1);
        chk("t2_wl",   {23'd0, wl_m}, 32'd3);
        chk("t2_cks",  cks_m, 32'd6);
        chk("t2_nwr",  qa_m.size(), 32'd3);
        for (int i = 0; i < 3 && i < qa_m.size(); i++) begin
            chk($sformatf("t2_addr%0d", i), qa_m[i], 32'(4 * i));
            chk($sformatf("t2_data%0d", i), qd_m[i], 32'(i + 1));
        end
        chk("t2_lsb_nwr", qd_l.size(), 32'd3);
        if (qd_l.size() > 0) chk("t2_lsb_data0", qd_l[0], 32'h01000000);
        chk("t2_lsb_cks", cks_l, 32'h06000000);
        clear_q();

        // byte order variant: 01 00 00 00
        pulse_start();
        send_word(32'h01000000, 1'b1);
        idle(2);
        chk("t3_lsb_done", {31'd0, done_l}, 32'd1);
        chk("t3_nwr_l", qd_l.size(), 32'd1);
        if (qd_l.size() > 0) chk("t3_lsb_data", qd_l[0], 32'h00000001);
        if (qd_m.size() > 0) chk("t3_msb_data", qd_m[0], 32'h01000000);
        clear_q();

        // in_last on 2nd byte of word 2
        pulse_start();
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        chk("t4_err",   {31'd0, err_m}, 32'd1);
        chk("t4_done",  {31'd0, done_m}, 32'd0);
        chk("t4_hold",  {31'd0, hold_m}, 32'd1);
        chk("t4_ready", {31'd0, bus_m.in_ready}, 32'd0);
        idle(2);
        chk("t4_nwr", qa_m.size(), 32'd1);
        chk("t4_wl",  {23'd0, wl_m}, 32'd1);
        clear_q();

        // overflow: 256 full words then one extra byte
        pulse_start();
        for (int w = 0; w < 256; w++) send_word(32'(w), 1'b0);
        send_byte(8'hAA, 1'b0);
        chk("t5_err",  {31'd0, err_m}, 32'd1);
        chk("t5_done", {31'd0, done_m}, 32'd0);
        idle(2);
        chk("t5_nwr",  qa_m.size(), 32'd256);
        if (qa_m.size() > 0) begin
            chk("t5_last_addr", qa_m[qa_m.size() - 1], 32'd1020);
            chk("t5_last_data", qd_m[qd_m.size() - 1], 32'd255);
        end
        chk("t5_wl",  {23'd0, wl_m}, 32'd256);
        chk("t5_cks", cks_m, 32'd32640);
        clear_q();

        // reset after 2 bytes of a word
        pulse_start();
        send_word(32'h01020304, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        reset = 1'b1;
        idle(1);
        chk_reset_state("t6");
        reset = 1'b0;
        idle(1);
        chk("t6_nwr_after_rst", qa_m.size(), 32'd1);
        clear_q();
        // start together with a valid byte: that byte must not be taken
        start = 1'b1; v = 1'b1; d = 8'h77;
        @(negedge clk);
        start = 1'b0; v = 1'b0;
        send_word(32'hCAFEBABE, 1'b1);
        idle(2);
        chk("t6_done", {31'd0, done_m}, 32'd1);
        chk("t6_nwr",  qa_m.size(), 32'd1);
        if (qa_m.size() > 0) begin
            chk("t6_addr", qa_m[0], 32'd0);
            chk("t6_data", qd_m[0], 32'hCAFEBABE);
        end
        chk("t6_cks", cks_m, 32'hCAFEBABE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
